// File: rtl/hw_field_ctrl_if.sv
// hw_field_ctrl_if: SW/HW request and field status bundle for one register
// field. The master side issues SW writes and HW requests. The slave side
// (hw_field_ctrl) owns the field flop and reports its state.
// Optional feature macro: HW_FIELD_PARITY_EN adds the parity_err signal.

interface hw_field_ctrl_if #(
  parameter int F_WIDTH = 4
);

  // Requests toward the field
  logic               sw_wr;
  logic [F_WIDTH-1:0] sw_wdata;
  logic               hw_pulse;
  logic [F_WIDTH-1:0] hw_value;
  logic               cnt_inc;
  logic               cnt_dec;
  logic [F_WIDTH-1:0] cnt_step;

  // Field state, all registered
  logic [F_WIDTH-1:0] field_value;
  logic               hw_modified;
  logic               cnt_ovf;
  logic               cnt_udf;
`ifdef HW_FIELD_PARITY_EN
  logic               parity_err;
`endif

  modport master (
    output sw_wr, sw_wdata, hw_pulse, hw_value, cnt_inc, cnt_dec, cnt_step,
    input  field_value, hw_modified, cnt_ovf, cnt_udf
`ifdef HW_FIELD_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  sw_wr, sw_wdata, hw_pulse, hw_value, cnt_inc, cnt_dec, cnt_step,
    output field_value, hw_modified, cnt_ovf, cnt_udf
`ifdef HW_FIELD_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/hw_field_ctrl.sv
// hw_field_ctrl: stateful register field. It owns the field flop and
// arbitrates SW writes against HW updates. The HW update kind is selected by
// HW_TYPE (RO/RW/CLR/SET/CNT). Counter mode has a step size, saturate or wrap
// behaviour, and sticky overflow/underflow flags.
// Optional feature macro: HW_FIELD_PARITY_EN. When it is defined, the module
// adds an even-parity flop over the field and a sticky parity_err output.

`ifndef HW_RO
`define HW_RO  0
`endif
`ifndef HW_RW
`define HW_RW  1
`endif
`ifndef HW_CLR
`define HW_CLR 2
`endif
`ifndef HW_SET
`define HW_SET 3
`endif
`ifndef HW_CNT
`define HW_CNT 4
`endif

module hw_field_ctrl #(
  parameter int                 F_WIDTH       = 4,
  parameter int                 HW_TYPE       = `HW_RW,
  parameter logic [F_WIDTH-1:0] RESET_VAL     = '0,
  parameter bit                 OVERFLOW_LOCK = 1'b1,
  parameter bit                 SW_PRIORITY   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  hw_field_ctrl_if.slave bus
);

  // The counter arithmetic carries one extra bit to expose the carry or borrow
  localparam int CW = F_WIDTH + 1;

  // Reject configurations that have no defined behaviour before anything is built
  if (F_WIDTH < 1 || F_WIDTH > 32) begin : g_bad_width
    $fatal(1, "hw_field_ctrl: F_WIDTH=%0d outside 1..32", F_WIDTH);
  end
  if (HW_TYPE != `HW_RO && HW_TYPE != `HW_RW && HW_TYPE != `HW_CLR &&
      HW_TYPE != `HW_SET && HW_TYPE != `HW_CNT) begin : g_bad_type
    $fatal(1, "hw_field_ctrl: unknown HW_TYPE=%0d", HW_TYPE);
  end

  logic [F_WIDTH-1:0] field_q, field_d;
  logic               hw_mod_q, hw_mod_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               field_upd;

  logic               hreq;
  logic [F_WIDTH-1:0] hw_nxt;
  logic               ev_ovf, ev_udf;
  logic [CW-1:0]      cnt_sum, cnt_diff;

  // HW request decode: the value HW wants to commit and whether it wants to commit it
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    hreq     = 1'b0;
    hw_nxt   = field_q;
    ev_ovf   = 1'b0;
    ev_udf   = 1'b0;
    cnt_sum  = {1'b0, field_q} + {1'b0, bus.cnt_step};
    cnt_diff = {1'b0, field_q} - {1'b0, bus.cnt_step};
    case (HW_TYPE)
      `HW_RW: begin
        hreq   = bus.hw_pulse;
        hw_nxt = bus.hw_value;
      end
      `HW_CLR: begin
        hreq   = |bus.hw_value;
        hw_nxt = field_q & ~bus.hw_value;
      end
      `HW_SET: begin
        hreq   = |bus.hw_value;
        hw_nxt = field_q | bus.hw_value;
      end
      `HW_CNT: begin
        // A simultaneous increment and decrement cancels out.
        hreq = bus.cnt_inc ^ bus.cnt_dec;
        if (bus.cnt_inc && !bus.cnt_dec) begin
          ev_ovf = cnt_sum[F_WIDTH];
          hw_nxt = (ev_ovf && OVERFLOW_LOCK) ? {F_WIDTH{1'b1}}
                                             : cnt_sum[F_WIDTH-1:0];
        end else if (bus.cnt_dec && !bus.cnt_inc) begin
          ev_udf = cnt_diff[F_WIDTH];
          hw_nxt = (ev_udf && OVERFLOW_LOCK) ? '0 : cnt_diff[F_WIDTH-1:0];
        end
      end
      default: begin
        // The read-only field never requests an update.
        hreq = 1'b0;
      end
    endcase
  end

  // SW/HW arbitration: choose the winner and derive the next field and flags
  always_comb begin
    field_d   = field_q;
    hw_mod_d  = 1'b0;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    field_upd = 1'b0;
    if (bus.sw_wr && (!hreq || SW_PRIORITY)) begin
      // The SW write commits. Any same-cycle HW request is dropped, and the counter flags restart from zero.
      field_d   = bus.sw_wdata;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      field_upd = 1'b1;
    end else if (hreq) begin
      // The HW update commits. Any same-cycle SW write is dropped.
      field_d   = hw_nxt;
      hw_mod_d  = 1'b1;
      ovf_d     = ovf_q | ev_ovf;
      udf_d     = udf_q | ev_udf;
      field_upd = 1'b1;
    end
  end

  // Field and status registers. Synchronous reset overrides every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: flops are written with non-blocking assignments so that every register samples the pre-edge values.
      field_q  <= RESET_VAL;
      hw_mod_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      field_q  <= field_d;
      hw_mod_q <= hw_mod_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.field_value = field_q;
  assign bus.hw_modified = hw_mod_q;
  assign bus.cnt_ovf     = ovf_q;
  assign bus.cnt_udf     = udf_q;

`ifdef HW_FIELD_PARITY_EN
  logic par_q;
  logic par_err_q;

  // Parity tracks every legal field update. A mismatch means the flop was corrupted.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q     <= ^RESET_VAL;
      par_err_q <= 1'b0;
    end else begin
      if (field_upd) begin
        par_q <= ^field_d;
      end
      if (bus.sw_wr) begin
        par_err_q <= 1'b0;
      end else if (par_q != ^field_q) begin
        par_err_q <= 1'b1;
      end
    end
  end

  assign bus.parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_hw_field_ctrl.sv
// tb_hw_field_ctrl: seven field instances share one input stream and cover
// every HW_TYPE, both overflow modes and both arbitration priorities. The
// driver updates an arithmetic reference model of each field and queues the
// expected state. A monitor pops the queue one cycle later and compares it
// with what the instances present.

`ifndef HW_RO
`define HW_RO  0
`endif
`ifndef HW_RW
`define HW_RW  1
`endif
`ifndef HW_CLR
`define HW_CLR 2
`endif
`ifndef HW_SET
`define HW_SET 3
`endif
`ifndef HW_CNT
`define HW_CNT 4
`endif

module tb_hw_field_ctrl;

  localparam int NI  = 7;
  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  // Per-instance configuration
  function automatic int cfg_type(input int i);
    case (i)
      0, 1:    return `HW_RW;
      2:       return `HW_CLR;
      3:       return `HW_SET;
      4, 5:    return `HW_CNT;
      default: return `HW_RO;
    endcase
  endfunction

  function automatic logic [W-1:0] cfg_rst(input int i);
    case (i)
      0:       return 4'h5;
      2:       return 4'hF;
      4:       return 4'hE;
      5:       return 4'h1;
      6:       return 4'h5;
      default: return 4'h0;
    endcase
  endfunction

  function automatic bit cfg_lock(input int i);
    return (i != 5);
  endfunction

  function automatic bit cfg_prio(input int i);
    return !(i == 1 || i == 3 || i == 5);
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sw_wr = 1'b0, hw_pulse = 1'b0, cnt_inc = 1'b0, cnt_dec = 1'b0;
  logic [W-1:0] sw_wdata = '0, hw_value = '0, cnt_step = '0;

  logic [W-1:0] fv  [NI];
  logic         hm  [NI];
  logic         ovf [NI];
  logic         udf [NI];
`ifdef HW_FIELD_PARITY_EN
  logic         perr[NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    hw_field_ctrl_if #(.F_WIDTH(W)) bus ();

    assign bus.sw_wr    = sw_wr;
    assign bus.sw_wdata = sw_wdata;
    assign bus.hw_pulse = hw_pulse;
    assign bus.hw_value = hw_value;
    assign bus.cnt_inc  = cnt_inc;
    assign bus.cnt_dec  = cnt_dec;
    assign bus.cnt_step = cnt_step;
    assign fv[g]  = bus.field_value;
    assign hm[g]  = bus.hw_modified;
    assign ovf[g] = bus.cnt_ovf;
    assign udf[g] = bus.cnt_udf;
`ifdef HW_FIELD_PARITY_EN
    assign perr[g] = bus.parity_err;
`endif

    hw_field_ctrl #(
      .F_WIDTH      (W),
      .HW_TYPE      (cfg_type(g)),
      .RESET_VAL    (cfg_rst(g)),
      .OVERFLOW_LOCK(cfg_lock(g)),
      .SW_PRIORITY  (cfg_prio(g))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  typedef struct packed {
    logic [NI-1:0][W-1:0] fv;
    logic [NI-1:0]        hm;
    logic [NI-1:0]        ovf;
    logic [NI-1:0]        udf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int m_fv  [NI];
  bit m_ovf [NI];
  bit m_udf [NI];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, idx, act, req, $time);
    end
  endtask

  // Advance the model by one clock with the current inputs and queue the result
  task automatic step_model();
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      bit hreq = 0;
      bit eo   = 0;
      bit eu   = 0;
      int nxt  = m_fv[i];
      bit hmx  = 0;
      int t;
      if (rst) begin
        m_fv[i]  = int'(cfg_rst(i));
        m_ovf[i] = 0;
        m_udf[i] = 0;
      end else begin
        case (cfg_type(i))
          `HW_RW:  begin hreq = hw_pulse; nxt = int'(hw_value); end
          `HW_CLR: begin hreq = (hw_value != 0); nxt = m_fv[i] & ~int'(hw_value) & MAX; end
          `HW_SET: begin hreq = (hw_value != 0); nxt = m_fv[i] | int'(hw_value); end
          `HW_CNT: begin
            hreq = (cnt_inc != cnt_dec);
            if (cnt_inc && !cnt_dec) begin
              t = m_fv[i] + int'(cnt_step);
              if (t > MAX) begin eo = 1; nxt = cfg_lock(i) ? MAX : t - (MAX + 1); end
              else nxt = t;
            end else if (cnt_dec && !cnt_inc) begin
              t = m_fv[i] - int'(cnt_step);
              if (t < 0) begin eu = 1; nxt = cfg_lock(i) ? 0 : t + (MAX + 1); end
              else nxt = t;
            end
          end
          default: hreq = 0;
        endcase
        if (sw_wr && (!hreq || cfg_prio(i))) begin
          m_fv[i]  = int'(sw_wdata);
          m_ovf[i] = 0;
          m_udf[i] = 0;
        end else if (hreq) begin
          m_fv[i]  = nxt;
          hmx      = 1;
          m_ovf[i] = m_ovf[i] | eo;
          m_udf[i] = m_udf[i] | eu;
        end
      end
      e.fv[i]  = W'(m_fv[i]);
      e.hm[i]  = hmx;
      e.ovf[i] = m_ovf[i];
      e.udf[i] = m_udf[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic apply(input bit r, input bit w, input logic [W-1:0] wd,
                       input bit p, input logic [W-1:0] hv,
                       input bit inc, input bit dec, input logic [W-1:0] st);
    @(negedge clk);
    rst = r; sw_wr = w; sw_wdata = wd; hw_pulse = p; hw_value = hv;
    cnt_inc = inc; cnt_dec = dec; cnt_step = st;
    step_model();
  endtask

  // Monitor: compare the oldest expectation with the registered outputs after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          check("field_value", i, 32'(fv[i]),  32'(e.fv[i]));
          check("hw_modified", i, 32'(hm[i]),  32'(e.hm[i]));
          check("cnt_ovf",     i, 32'(ovf[i]), 32'(e.ovf[i]));
          check("cnt_udf",     i, 32'(udf[i]), 32'(e.udf[i]));
`ifdef HW_FIELD_PARITY_EN
          check("parity_err",  i, 32'(perr[i]), 32'h0);
`endif
        end
      end
    end
  end

  initial begin
`ifdef HW_FIELD_PARITY_EN
    logic [W-1:0] flip;
`endif
    // Two reset cycles, then the directed corner cases, then random traffic
    apply(1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    apply(1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    apply(0, 0, 4'h0, 0, 4'h3, 0, 0, 4'h0);   // CLR mask 3: F -> C
    apply(0, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0);   // hw_modified falls
    apply(0, 0, 4'h0, 0, 4'h0, 1, 0, 4'h3);   // E + 3 saturates
    apply(0, 1, 4'h0, 0, 4'h0, 0, 0, 4'h0);   // SW write clears flags
    apply(0, 1, 4'h1, 0, 4'h0, 0, 0, 4'h0);
    apply(0, 0, 4'h0, 0, 4'h0, 0, 1, 4'h2);   // 1 - 2 wraps or clamps
    apply(0, 0, 4'h0, 0, 4'h0, 1, 1, 4'h5);   // inc and dec cancel
    apply(0, 1, 4'hA, 1, 4'h3, 0, 0, 4'h0);   // SW vs HW collision
    apply(0, 1, 4'h7, 0, 4'h0, 1, 0, 4'hF);   // SW vs counter collision
    apply(1, 1, 4'h9, 1, 4'hF, 1, 0, 4'h1);   // reset beats everything
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) == 0, W'($urandom),
            $urandom_range(0, 2) == 0,
            ($urandom_range(0, 3) == 0) ? 4'h0 : W'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 5) == 0) ? 4'h0 : W'($urandom));
    end
    apply(0, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drain", 0, 32'(exp_q.size()), 32'h0);

`ifdef HW_FIELD_PARITY_EN
    // Corrupt instance 0's field flop directly; the parity checker must flag it
    @(negedge clk);
    flip = gen_dut[0].u_dut.field_q ^ 4'h1;
    force gen_dut[0].u_dut.field_q = flip;
    @(posedge clk);
    #1;
    release gen_dut[0].u_dut.field_q;
    check("parity_err_flip", 0, 32'(perr[0]), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
